// File: rtl/play_core.sv
// play_core: streams one chunk of 16-bit samples from SRAM to the codec.
// Each word is read from SRAM and held in a buffer. It is handed to the codec
// on the next sample slot, and then the next word is fetched.
//
// Handshakes:
//   SRAM read: o_sram_rd is a level valid. It stays high with a stable
//   o_sram_addr until i_sram_ack returns the data. The ack may arrive in the
//   same cycle as the request. If an abort happens in that cycle, the ack is
//   ignored.
//   Codec: i_dac_req is a one-cycle request for a sample. A consumed request
//   is answered one cycle later by an o_dac_valid pulse, which lands in the
//   same cycle that o_dac_data changes.
module play_core #(
    parameter int unsigned CHUNK_WORDS = 23'h100000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        play_start,
    input  logic [22:0] play_addr,
    input  logic        play_speed,
    input  logic        play_pause,
    input  logic        play_stop,
    output logic        play_done,
    output logic [22:0] o_sram_addr,
    output logic        o_sram_rd,
    input  logic        i_sram_ack,
    input  logic [15:0] i_sram_data,
    input  logic        i_dac_req,
    output logic [15:0] o_dac_data,
    output logic        o_dac_valid,
    output logic        o_busy,
    output logic [2:0]  o_dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_HOLD     = 3'd2,
        ST_DONE     = 3'd3,
        ST_WAIT_REL = 3'd4
    } state_t;

    // The count is one bit wider than the address, so a whole chunk fits in it.
    // The sum gets one more bit, so the end-of-chunk compare cannot wrap.
    localparam logic [24:0] CHUNK_LIMIT = 25'(CHUNK_WORDS);

    state_t      state_q, state_d;
    logic [22:0] addr_q;
    logic [23:0] cnt_q;
    logic [1:0]  step_q;
    logic [15:0] sample_buf_q;
    logic [15:0] dac_data_q;
    logic        dac_valid_q;

    logic        do_start;
    logic        do_capture;
    logic        do_consume;
    logic        abort;
    logic [24:0] cnt_sum;

    assign abort   = play_stop || !play_start;
    assign cnt_sum = {1'b0, cnt_q} + 25'(step_q);

    // Next-state logic plus the datapath enables for each state.
    always_comb begin
        state_d    = state_q;
        do_start   = 1'b0;
        do_capture = 1'b0;
        do_consume = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (play_start) begin
                    do_start = 1'b1;
                    state_d  = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // An abort takes priority, so an ack that arrives with it is dropped.
                if (abort) begin
                    state_d = ST_DONE;
                end else if (i_sram_ack) begin
                    do_capture = 1'b1;
                    state_d    = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // Stop beats a sample request in the same cycle. Pause only holds off consumption.
                if (abort) begin
                    state_d = ST_DONE;
                end else if (i_dac_req && !play_pause) begin
                    do_consume = 1'b1;
                    state_d    = (cnt_sum >= CHUNK_LIMIT) ? ST_DONE : ST_FETCH;
                end
            end
            ST_DONE: begin
                state_d = ST_WAIT_REL;
            end
            ST_WAIT_REL: begin
                // Wait here until start is released, so a held start cannot begin a second run.
                if (!play_start) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath: latch the start parameters, capture read data and emit samples.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            addr_q       <= 23'd0;
            cnt_q        <= 24'd0;
            step_q       <= 2'd1;
            sample_buf_q <= 16'd0;
            dac_data_q   <= 16'd0;
            dac_valid_q  <= 1'b0;
        end else begin
            dac_valid_q <= do_consume;
            if (do_start) begin
                addr_q <= play_addr;
                step_q <= play_speed ? 2'd2 : 2'd1;
                cnt_q  <= 24'd0;
            end
            if (do_capture) begin
                sample_buf_q <= i_sram_data;
            end
            if (do_consume) begin
                dac_data_q <= sample_buf_q;
                addr_q     <= addr_q + 23'(step_q);
                cnt_q      <= cnt_sum[23:0];
            end
        end
    end

    assign o_sram_rd   = (state_q == ST_FETCH);
    assign o_sram_addr = addr_q;
    assign play_done   = (state_q == ST_DONE);
    assign o_busy      = (state_q != ST_IDLE);
    assign o_dac_data  = dac_data_q;
    assign o_dac_valid = dac_valid_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_play_core.sv
// Testbench for play_core with CHUNK_WORDS=4 and an SRAM that acks one cycle after the read.
module tb_play_core;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_HOLD  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        play_start = 1'b0;
    logic [22:0] play_addr = 23'd0;
    logic        play_speed = 1'b0;
    logic        play_pause;
    logic        play_stop = 1'b0;
    logic        play_done;
    logic [22:0] o_sram_addr;
    logic        o_sram_rd;
    logic        i_sram_ack = 1'b0;
    logic [15:0] i_sram_data = 16'd0;
    logic        i_dac_req;
    logic [15:0] o_dac_data;
    logic        o_dac_valid;
    logic        o_busy;
    logic [2:0]  o_dbg_state;

    // Manual and random stimulus sources, chosen by rand_mode.
    logic rand_mode = 1'b0;
    logic req_man = 1'b0, pause_man = 1'b0;
    logic req_rnd = 1'b0, pause_rnd = 1'b0;
    assign i_dac_req  = rand_mode ? req_rnd : req_man;
    assign play_pause = rand_mode ? pause_rnd : pause_man;

    int checks = 0;
    int failures = 0;
    int sample_cnt = 0;
    int done_cnt = 0;
    logic prev_valid = 1'b0;
    logic rd_seen = 1'b0;
    logic [15:0] exp_w;
    logic [15:0] exp_q[$];
    logic [22:0] exp_rd_q[$];
    logic [22:0] rd_q[$];

    typedef struct {
        logic [22:0] addr;
        logic        speed;
        int          exp_samples;
        logic [22:0] exp_last;
    } vec_t;
    vec_t vecs[5];

    play_core #(.CHUNK_WORDS(4)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .play_start  (play_start),
        .play_addr   (play_addr),
        .play_speed  (play_speed),
        .play_pause  (play_pause),
        .play_stop   (play_stop),
        .play_done   (play_done),
        .o_sram_addr (o_sram_addr),
        .o_sram_rd   (o_sram_rd),
        .i_sram_ack  (i_sram_ack),
        .i_sram_data (i_sram_data),
        .i_dac_req   (i_dac_req),
        .o_dac_data  (o_dac_data),
        .o_dac_valid (o_dac_valid),
        .o_busy      (o_busy),
        .o_dbg_state (o_dbg_state)
    );

    // Clock.
    always #5 i_clk = ~i_clk;

    function automatic logic [15:0] mem_word(input logic [22:0] a);
        return a[15:0] ^ 16'hA5C3 ^ {a[22:16], 9'd0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // SRAM model. It acks one cycle after it sees o_sram_rd and logs every address it serves.
    always @(negedge i_clk) begin
        if (!i_rst_n || !o_sram_rd) begin
            i_sram_ack = 1'b0;
            rd_seen    = 1'b0;
        end else if (rd_seen && !i_sram_ack) begin
            i_sram_ack  = 1'b1;
            i_sram_data = mem_word(o_sram_addr);
            rd_q.push_back(o_sram_addr);
        end else begin
            rd_seen = 1'b1;
        end
    end

    // Random codec requests, never on two cycles in a row, plus random pause.
    always @(negedge i_clk) begin
        if (rand_mode) begin
            req_rnd   = !req_rnd && ($urandom_range(0, 2) == 0);
            pause_rnd = ($urandom_range(0, 5) == 0);
        end else begin
            req_rnd   = 1'b0;
            pause_rnd = 1'b0;
        end
    end

    // Scoreboard and monitor.
    always @(negedge i_clk) begin
        if (play_done) done_cnt++;
        if (o_dac_valid) begin
            sample_cnt++;
            check("valid_gap", 32'(prev_valid), 32'd0);
            check("sample_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                exp_w = exp_q.pop_front();
                check("sample_data", 32'(o_dac_data), 32'(exp_w));
            end
        end
        if (o_sram_rd) check("rd_implies_busy", 32'(o_busy), 32'd1);
        prev_valid = o_dac_valid;
    end

    // Reference model: ceil(4/step) samples, read from addr + i*step modulo 2^23.
    task automatic load_model(input logic [22:0] addr, input logic spd, input int max_n);
        int s;
        int n;
        logic [22:0] a;
        s = spd ? 2 : 1;
        n = (4 + s - 1) / s;
        exp_q.delete();
        exp_rd_q.delete();
        for (int i = 0; i < n; i++) begin
            a = addr + 23'(i * s);
            exp_rd_q.push_back(a);
            if (i < max_n) exp_q.push_back(mem_word(a));
        end
        sample_cnt = 0;
        done_cnt   = 0;
        rd_q.delete();
    endtask

    task automatic step_clk();
        @(negedge i_clk);
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget, input string name);
        int n;
        n = 0;
        while (o_dbg_state !== st && n < budget) begin
            step_clk();
            n++;
        end
        check(name, 32'(o_dbg_state), 32'(st));
    endtask

    task automatic strobe();
        req_man = 1'b1;
        step_clk();
        req_man = 1'b0;
    endtask

    task automatic release_start(input string tag);
        wait_state(S_DONE, 30, {tag, "_done_state"});
        step_clk();
        check({tag, "_wait_rel_no_done"}, 32'(play_done), 32'd0);
        play_start = 1'b0;
        step_clk();
        step_clk();
        check({tag, "_idle"}, 32'(o_dbg_state), 32'(S_IDLE));
    endtask

    task automatic verify_run(input string tag);
        check({tag, "_samples"}, sample_cnt, exp_rd_q.size());
        check({tag, "_done_pulses"}, done_cnt, 32'd1);
        check({tag, "_reads"}, rd_q.size(), exp_rd_q.size());
        for (int i = 0; i < exp_rd_q.size() && i < rd_q.size(); i++)
            check({tag, "_rd_addr"}, 32'(rd_q[i]), 32'(exp_rd_q[i]));
        check({tag, "_exp_left"}, exp_q.size(), 32'd0);
    endtask

    task automatic run_play(input logic [22:0] addr, input logic spd, input string tag);
        int n;
        load_model(addr, spd, 8);
        play_addr  = addr;
        play_speed = spd;
        play_start = 1'b1;
        rand_mode  = 1'b1;
        step_clk();
        // The core has latched its parameters, so these changes must have no effect.
        play_addr  = 23'($urandom);
        play_speed = 1'($urandom_range(0, 1));
        n = 0;
        while (!play_done && n < 500) begin
            step_clk();
            n++;
        end
        check({tag, "_done_seen"}, 32'(play_done), 32'd1);
        rand_mode = 1'b0;
        step_clk();
        play_start = 1'b0;
        step_clk();
        step_clk();
        check({tag, "_idle"}, 32'(o_dbg_state), 32'(S_IDLE));
        verify_run(tag);
    endtask

    initial begin
        vecs[0] = '{addr: 23'h000010, speed: 1'b0, exp_samples: 4, exp_last: 23'h000013};
        vecs[1] = '{addr: 23'h7FFFFF, speed: 1'b0, exp_samples: 4, exp_last: 23'h000002};
        vecs[2] = '{addr: 23'h7FFFFF, speed: 1'b1, exp_samples: 2, exp_last: 23'h000001};
        vecs[3] = '{addr: 23'h123456, speed: 1'b1, exp_samples: 2, exp_last: 23'h123458};
        vecs[4] = '{addr: 23'h7FFFFD, speed: 1'b1, exp_samples: 2, exp_last: 23'h7FFFFF};

        // Reset.
        i_rst_n = 1'b0;
        repeat (3) step_clk();
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_rd", 32'(o_sram_rd), 32'd0);
        check("rst_done", 32'(play_done), 32'd0);
        check("rst_valid", 32'(o_dac_valid), 32'd0);
        check("rst_data", 32'(o_dac_data), 32'd0);
        check("rst_addr", 32'(o_sram_addr), 32'd0);
        i_rst_n = 1'b1;
        step_clk();
        check("idle_after_rst", 32'(o_dbg_state), 32'(S_IDLE));

        // Normal play from 0x100 at single speed.
        load_model(23'h100, 1'b0, 8);
        play_addr = 23'h100; play_speed = 1'b0; play_start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_state(S_HOLD, 20, "norm_hold");
            strobe();
        end
        release_start("norm");
        verify_run("norm");

        // Double speed with the address wrapping past the top of memory.
        load_model(23'h7FFFFE, 1'b1, 8);
        play_addr = 23'h7FFFFE; play_speed = 1'b1; play_start = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wait_state(S_HOLD, 20, "dbl_hold");
            strobe();
        end
        release_start("dbl");
        verify_run("dbl");
        if (rd_q.size() == 2) check("dbl_wrap_addr", 32'(rd_q[1]), 32'd0);

        // Stop arrives together with a sample request in HOLD.
        load_model(23'h200, 1'b0, 1);
        play_addr = 23'h200; play_speed = 1'b0; play_start = 1'b1;
        wait_state(S_HOLD, 20, "stop_hold1");
        strobe();
        wait_state(S_HOLD, 20, "stop_hold2");
        req_man = 1'b1; play_stop = 1'b1;
        step_clk();
        req_man = 1'b0; play_stop = 1'b0;
        check("stop_valid", 32'(o_dac_valid), 32'd0);
        check("stop_done", 32'(play_done), 32'd1);
        step_clk();
        check("stop_wait_rel", 32'(o_dbg_state), 32'(S_WAIT));
        check("stop_done_low", 32'(play_done), 32'd0);
        play_start = 1'b0;
        step_clk();
        check("stop_idle", 32'(o_dbg_state), 32'(S_IDLE));
        check("stop_samples", sample_cnt, 32'd1);
        check("stop_done_pulses", done_cnt, 32'd1);
        exp_q.delete();

        // Pause across three sample requests, then resume.
        load_model(23'h300, 1'b0, 8);
        play_addr = 23'h300; play_speed = 1'b0; play_start = 1'b1;
        wait_state(S_HOLD, 20, "pause_hold1");
        strobe();
        wait_state(S_HOLD, 20, "pause_hold2");
        pause_man = 1'b1;
        for (int i = 0; i < 3; i++) begin
            strobe();
            step_clk();
            check("pause_state", 32'(o_dbg_state), 32'(S_HOLD));
            check("pause_samples", sample_cnt, 32'd1);
            check("pause_data", 32'(o_dac_data), 32'(mem_word(23'h300)));
        end
        pause_man = 1'b0;
        strobe();
        check("resume_valid", 32'(o_dac_valid), 32'd1);
        check("resume_data", 32'(o_dac_data), 32'(mem_word(23'h301)));
        for (int i = 0; i < 2; i++) begin
            wait_state(S_HOLD, 20, "pause_hold3");
            strobe();
        end
        release_start("pause");
        verify_run("pause");

        // Start held high after completion must not start a second run.
        load_model(23'h400, 1'b1, 8);
        play_addr = 23'h400; play_speed = 1'b1; play_start = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wait_state(S_HOLD, 20, "held_hold");
            strobe();
        end
        wait_state(S_DONE, 20, "held_done_state");
        for (int i = 0; i < 5; i++) begin
            step_clk();
            check("held_wait_rel", 32'(o_dbg_state), 32'(S_WAIT));
            check("held_reads", rd_q.size(), 32'd2);
        end
        play_start = 1'b0;
        step_clk();
        check("held_idle", 32'(o_dbg_state), 32'(S_IDLE));
        verify_run("held");

        // Asynchronous reset while a read is outstanding.
        load_model(23'h500, 1'b0, 0);
        play_addr = 23'h500; play_speed = 1'b0; play_start = 1'b1;
        wait_state(S_FETCH, 10, "arst_fetch");
        #2 i_rst_n = 1'b0;
        #1;
        check("arst_rd", 32'(o_sram_rd), 32'd0);
        check("arst_busy", 32'(o_busy), 32'd0);
        check("arst_data", 32'(o_dac_data), 32'd0);
        play_start = 1'b0;
        step_clk();
        step_clk();
        i_rst_n = 1'b1;
        step_clk();
        check("arst_idle", 32'(o_dbg_state), 32'(S_IDLE));
        check("arst_no_done", done_cnt, 32'd0);

        // Table vectors with random requests and pauses.
        for (int i = 0; i < 5; i++) begin
            run_play(vecs[i].addr, vecs[i].speed, "vec");
            check("vec_count", sample_cnt, vecs[i].exp_samples);
            if (rd_q.size() != 0) check("vec_last_addr", 32'(rd_q[rd_q.size() - 1]), 32'(vecs[i].exp_last));
        end

        // Fully random runs.
        for (int i = 0; i < 6; i++) begin
            run_play(23'($urandom), 1'($urandom_range(0, 1)), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/play_core.md
PLAY_CORE -- requirements
Module: play_core

Interface
REQ-001 Parameter CHUNK_WORDS, default 23'h100000, number of 16-bit words in one chunk.
REQ-002 Port i_clk  input  1  system clock; all logic SHALL be on its rising edge.
REQ-003 Port i_rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port play_start  input  1  level request from control core, held high for the whole PLAY state.
REQ-005 Port play_addr  input  23  chunk start word address (control core play_select[1]).
REQ-006 Port play_speed  input  1  0 = address step 1, 1 = address step 2.
REQ-007 Port play_pause  input  1  level; while high, no samples are consumed.
REQ-008 Port play_stop  input  1  early-termination request.
REQ-009 Port play_done  output  1  one-cycle completion pulse to control core.
REQ-010 Port o_sram_addr  output  23  SRAM word read address.
REQ-011 Port o_sram_rd  output  1  SRAM read request, level.
REQ-012 Port i_sram_ack  input  1  read data valid; may assert in the same cycle as o_sram_rd.
REQ-013 Port i_sram_data  input  16  read data, sampled when i_sram_ack=1.
REQ-014 Port i_dac_req  input  1  one-cycle strobe per codec sample slot.
REQ-015 Port o_dac_data  output  16  current sample to codec.
REQ-016 Port o_dac_valid  output  1  one-cycle pulse when o_dac_data updates.
REQ-017 Port o_busy  output  1  high in any state other than IDLE.

Function
REQ-018 The FSM SHALL have states IDLE, FETCH, HOLD, DONE and WAIT_REL.
REQ-019 IDLE: on play_start=1, latch addr<=play_addr, step<=(play_speed?2:1), cnt<=0; next state FETCH.
REQ-020 FETCH: o_sram_rd=1 and o_sram_addr=addr; on i_sram_ack=1, capture i_sram_data into buf; next state HOLD.
REQ-021 HOLD: on i_dac_req=1 with play_pause=0: o_dac_data<=buf, o_dac_valid=1 the next cycle, addr<=addr+step, cnt<=cnt+step.
REQ-022 HOLD transition after a consumed sample: DONE if cnt+step >= CHUNK_WORDS, else FETCH.
REQ-023 Samples emitted per full chunk SHALL be ceil(CHUNK_WORDS/step).
REQ-024 play_pause=1 SHALL be honoured in HOLD only; i_dac_req is ignored, and o_dac_data holds its last value.
REQ-025 A read in FETCH SHALL complete regardless of play_pause.
REQ-026 play_stop=1 or play_start=0 in FETCH or HOLD SHALL go to DONE on the next edge, dropping o_sram_rd and discarding any ack in that cycle.
REQ-027 Stop and i_dac_req in the same HOLD cycle: stop wins, and no sample is emitted.
REQ-028 DONE: play_done=1 for exactly one cycle; next state WAIT_REL.
REQ-029 WAIT_REL: play_done=0; return to IDLE only when play_start=0, so a held start cannot retrigger.
REQ-030 addr SHALL wrap modulo 2^23; cnt is 24 bits, so it cannot overflow.
REQ-031 o_sram_rd SHALL be 1 only in FETCH; o_dac_valid SHALL never be high in two consecutive cycles.
REQ-032 play_addr and play_speed changes after the IDLE latch SHALL have no effect until the next start.

Reset
REQ-033 i_rst_n=0 SHALL immediately force IDLE, addr=0, cnt=0, buf=0, step=1, o_dac_data=0, and o_sram_rd, o_dac_valid, play_done, o_busy all 0.
REQ-034 Reset mid-playback SHALL abandon the transfer with no play_done pulse.
REQ-035 After reset release, the block SHALL wait in IDLE for play_start=1, even if play_start was already high.

Verification (bench CHUNK_WORDS=4, ack one cycle after rd)
REQ-036 Normal play: play_addr=0x100, speed=0, four i_dac_req strobes returning data A,B,C,D -> reads at 0x100..0x103, o_dac_data A,B,C,D each with one o_dac_valid pulse, then one play_done pulse.
REQ-037 Double speed: play_addr=0x7FFFFE, speed=1 -> reads at 0x7FFFFE then 0x000000 (wrap), two samples, then play_done.
REQ-038 Stop: play_stop pulsed in HOLD together with i_dac_req after the first sample -> no second o_dac_valid, play_done one cycle later, then IDLE after play_start falls.
REQ-039 Pause: play_pause=1 across three i_dac_req strobes in HOLD -> no o_dac_valid and o_dac_data unchanged; resuming emits the next sample on the next strobe.
REQ-040 Held start: play_start kept high 5 cycles past play_done -> exactly one play_done, no new SRAM read; IDLE on play_start fall.
REQ-041 Async reset while o_sram_rd=1 -> o_sram_rd=0 and o_busy=0 before the next clock edge, and play_done is never asserted.
